// File: rtl/pwm_det_pkg.sv
// Shared defaults and helpers for the PWM high/low phase detector.
// Holds the counter width, synchronizer depth and saturating increment.
package pwm_det_pkg;

  localparam int DEFAULT_CNT_WIDTH   = 32;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int MAX_CNT_WIDTH       = 64;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(
    input logic [MAX_CNT_WIDTH-1:0] value,
    input int unsigned              width
  );
    logic [MAX_CNT_WIDTH-1:0] limit;
    limit = (width >= MAX_CNT_WIDTH) ? '1
          : ((MAX_CNT_WIDTH'(1) << width) - MAX_CNT_WIDTH'(1));
    return (value >= limit) ? limit : value + MAX_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pwm_phase_counter.sv
// Measures one PWM phase: restarts at 1 on its opening edge, saturates,
// and publishes the length on its closing edge once armed.
module pwm_phase_counter
  import pwm_det_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic                 latch,
  input  logic                 arm,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 ready
);

  logic [CNT_WIDTH-1:0] cnt_reg;
  logic                 armed_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      count     <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (clear)
        cnt_reg <= CNT_WIDTH'(1);
      else if (count_en)
        cnt_reg <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(cnt_reg), CNT_WIDTH));
      if (arm)
        armed_reg <= 1'b1;
      // The phase open at reset is never reported: armed only by a seen opening edge.
      if (latch && armed_reg) begin
        count <= cnt_reg;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_detector.sv
// Synchronizes an asynchronous PWM input and reports the length of each
// completed high and low phase with a one-cycle ready pulse.
module pwm_detector
  import pwm_det_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] count_high_pwm,
  output logic [CNT_WIDTH-1:0] count_low_pwm,
  output logic                 hready_intr,
  output logic                 lready_intr
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   pwm_d;
  logic                   pwm_s;
  logic                   rise;
  logic                   fall;

  // SYNC_STAGES must be at least 2 for the shift below to be well formed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
      pwm_d    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
      pwm_d    <= pwm_s;
    end
  end

  assign pwm_s = sync_reg[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;
  assign fall  = ~pwm_s & pwm_d;

  pwm_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_high (
    .clk      (clk),
    .reset    (reset),
    .clear    (rise),
    .count_en (pwm_s),
    .latch    (fall),
    .arm      (rise),
    .count    (count_high_pwm),
    .ready    (hready_intr)
  );

  pwm_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_low (
    .clk      (clk),
    .reset    (reset),
    .clear    (fall),
    .count_en (~pwm_s),
    .latch    (rise),
    .arm      (fall),
    .count    (count_low_pwm),
    .ready    (lready_intr)
  );

endmodule

// File: tb/tb_pwm_detector.sv
// Directed bench for pwm_detector: a 32-bit instance for the main scenarios
// and an 8-bit instance for counter saturation.
module tb_pwm_detector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pwm;
  logic [31:0] count_high;
  logic [31:0] count_low;
  logic        hready;
  logic        lready;

  logic        reset8_n;
  logic        pwm8;
  logic [7:0]  count8_high;
  logic [7:0]  count8_low;
  logic        hready8;
  logic        lready8;

  int total = 0;
  int bad   = 0;

  int hp = 0, lp = 0, both = 0, hp8 = 0;

  always #5 clk = ~clk;

  pwm_detector dut (
    .clk            (clk),
    .reset          (reset_n),
    .pwm_in         (pwm),
    .count_high_pwm (count_high),
    .count_low_pwm  (count_low),
    .hready_intr    (hready),
    .lready_intr    (lready)
  );

  pwm_detector #(.CNT_WIDTH(8)) dut8 (
    .clk            (clk),
    .reset          (reset8_n),
    .pwm_in         (pwm8),
    .count_high_pwm (count8_high),
    .count_low_pwm  (count8_low),
    .hready_intr    (hready8),
    .lready_intr    (lready8)
  );

  always @(negedge clk) begin
    if (hready) hp++;
    if (lready) lp++;
    if (hready && lready) both++;
    if (hready8) hp8++;
  end

  // Holds pwm at level for n rising edges; returns just after a falling edge.
  task automatic drive(input logic level, input int n);
    pwm = level;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive8(input logic level, input int n);
    pwm8 = level;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 20; i++) begin
      pwm = i[0];
      @(negedge clk);
    end
    #1;
    total++;
    if (count_high !== 32'd0 || count_low !== 32'd0 || hready !== 1'b0 || lready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: high=%0d low=%0d hr=%b lr=%b, want all 0", count_high, count_low, hready, lready);
    end
    reset_n  = 1'b1;
    reset8_n = 1'b1;
    drive(1'b0, 30);
    total++;
    if (count_high !== 32'd0 || count_low !== 32'd0 || hp !== 0 || lp !== 0) begin
      bad++;
      $display("FAIL reset_release: high=%0d low=%0d hp=%0d lp=%0d, want 0 0 0 0", count_high, count_low, hp, lp);
    end
    $display("reset test: high=%0d low=%0d pulses=%0d/%0d", count_high, count_low, hp, lp);
  endtask

  task automatic test_first_phase;
    int hp0, lp0;
    hp0 = hp;
    lp0 = lp;
    drive(1'b0, 7812);
    drive(1'b1, 23437);
    total++;
    if (lp !== lp0 || hp !== hp0) begin
      bad++;
      $display("FAIL first_rise_no_report: hp=%0d lp=%0d, want hp=%0d lp=%0d", hp, lp, hp0, lp0);
    end
    pwm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (hready !== (i == 2)) begin
        bad++;
        $display("FAIL fall_latency edge %0d: hready=%b, want %b", i + 1, hready, (i == 2));
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (count_high !== 32'd23437 || hp !== hp0 + 1) begin
      bad++;
      $display("FAIL first_high: count=%0d pulses=%0d, want 23437 and %0d", count_high, hp, hp0 + 1);
    end
    drive(1'b0, 20);
    $display("first phase: count_high=%0d hready pulses=%0d", count_high, hp - hp0);
  endtask

  task automatic test_pwm_steady;
    int hp0, lp0, b0;
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, 25);
      drive(1'b0, 75);
    end
    hp0 = hp;
    lp0 = lp;
    b0  = both;
    for (int p = 0; p < 4; p++) begin
      drive(1'b1, 25);
      drive(1'b0, 75);
    end
    total++;
    if (count_high !== 32'd25 || count_low !== 32'd75) begin
      bad++;
      $display("FAIL pwm_counts: high=%0d low=%0d, want 25 75", count_high, count_low);
    end
    total++;
    if (hp - hp0 !== 4 || lp - lp0 !== 4 || both !== b0) begin
      bad++;
      $display("FAIL pwm_pulses: h=%0d l=%0d both=%0d, want 4 4 0", hp - hp0, lp - lp0, both - b0);
    end
    $display("steady pwm: high=%0d low=%0d hpulses=%0d lpulses=%0d", count_high, count_low, hp - hp0, lp - lp0);
  endtask

  task automatic test_glitch;
    int hp0;
    drive(1'b0, 200);
    hp0 = hp;
    drive(1'b1, 1);
    drive(1'b0, 300);
    total++;
    if (count_high !== 32'd1 || hp !== hp0 + 1) begin
      bad++;
      $display("FAIL glitch_high: count=%0d pulses=%0d, want 1 and 1", count_high, hp - hp0);
    end
    drive(1'b1, 10);
    drive(1'b0, 10);
    total++;
    if (count_low !== 32'd300 || count_high !== 32'd10) begin
      bad++;
      $display("FAIL glitch_low: low=%0d high=%0d, want 300 10", count_low, count_high);
    end
    $display("glitch: high=%0d low=%0d", count_high, count_low);
  endtask

  task automatic test_saturation;
    int hp0;
    hp0 = hp8;
    drive8(1'b0, 10);
    drive8(1'b1, 300);
    drive8(1'b0, 10);
    total++;
    if (count8_high !== 8'd255 || hp8 !== hp0 + 1) begin
      bad++;
      $display("FAIL saturate: count=%0d pulses=%0d, want 255 and 1", count8_high, hp8 - hp0);
    end
    drive8(1'b1, 40);
    drive8(1'b0, 10);
    total++;
    if (count8_high !== 8'd40 || count8_low !== 8'd10) begin
      bad++;
      $display("FAIL after_saturate: high=%0d low=%0d, want 40 10", count8_high, count8_low);
    end
    $display("saturation: high=%0d low=%0d", count8_high, count8_low);
  endtask

  task automatic test_async_reset;
    int hp0, lp0;
    drive(1'b1, 20);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (count_high !== 32'd0 || count_low !== 32'd0 || hready !== 1'b0 || lready !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: high=%0d low=%0d hr=%b lr=%b, want all 0", count_high, count_low, hready, lready);
    end
    pwm = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    hp0 = hp;
    lp0 = lp;
    drive(1'b0, 15);
    drive(1'b1, 20);
    total++;
    if (count_high !== 32'd0 || hp !== hp0 || lp !== lp0) begin
      bad++;
      $display("FAIL restart_quiet: high=%0d hp=%0d lp=%0d, want 0 and no pulses", count_high, hp - hp0, lp - lp0);
    end
    drive(1'b0, 30);
    total++;
    if (count_high !== 32'd20 || count_low !== 32'd0 || hp !== hp0 + 1 || lp !== lp0) begin
      bad++;
      $display("FAIL restart_high: high=%0d low=%0d hp=%0d lp=%0d, want 20 0 1 0", count_high, count_low, hp - hp0, lp - lp0);
    end
    drive(1'b1, 20);
    drive(1'b0, 10);
    total++;
    if (count_low !== 32'd30 || lp !== lp0 + 1) begin
      bad++;
      $display("FAIL restart_low: low=%0d lp=%0d, want 30 1", count_low, lp - lp0);
    end
    $display("async reset: high=%0d low=%0d", count_high, count_low);
  endtask

  initial begin
    reset_n  = 1'b0;
    reset8_n = 1'b0;
    pwm      = 1'b0;
    pwm8     = 1'b0;
    @(negedge clk);
    #1;
    test_reset;
    test_first_phase;
    test_pwm_steady;
    test_glitch;
    test_saturation;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
